// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: splits one word/byte load or store into little-endian
// byte beats on a byte-wide synchronous memory port and returns the result
// over a valid/ready response channel.
//
// Build option: define LSU_SIGN_EXT_EN to sign-extend byte loads (lb);
// without it byte loads are zero-extended (lbu). Word loads are unaffected.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request, req_ready high
// ACCESS | one memory beat per cycle at addr+cnt
// DRAIN  | no beat; collect the read byte returned for the last beat
// RESP   | response held on rsp_* until rsp_ready
//
// DATA_WIDTH must be 32: the beat count and byte lane indexing assume four
// byte lanes.

module lsu_byte_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_a_type,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

`ifdef LSU_SIGN_EXT_EN
  localparam bit SIGN_EXT = 1'b1;
`else
  localparam bit SIGN_EXT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic                  byte_q, byte_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [1:0]            cnt_q, cnt_d;
  // last beat index: N-1 (0 for byte, 3 for word)
  logic [1:0]            last_q, last_d;
  // read data for beat cnt-1 arrives while beat cnt is being issued
  logic [1:0]            cnt_m1;

  assign cnt_m1 = cnt_q - 2'd1;

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          byte_d  = req_a_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = 2'd0;
          last_d  = req_a_type ? 2'd0 : 2'd3;
          // misaligned words are rejected without touching memory
          if (!req_a_type && (req_addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_WIDTH'(cnt_q);
        mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        if (!we_q && (cnt_q != 2'd0)) begin
          rdata_d[{cnt_m1, 3'b000} +: 8] = mem_rdata;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_q) begin
          state_d = we_q ? S_RESP : S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (byte_q) begin
          rdata_d = {{(DATA_WIDTH-8){SIGN_EXT & mem_rdata[7]}}, mem_rdata};
        end else begin
          rdata_d[{last_q, 3'b000} +: 8] = mem_rdata;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store sequencer consuming the byte/word access-type flag (a_type) and ALU-computed address that the ALU decoding stage produces for load/store instructions.
- Converts one 32-bit word or 8-bit byte request into little-endian beats on a byte-wide synchronous data memory port.
- Returns load data or store completion over a valid/ready response channel.
- Sits between execute stage and data memory.

Parameters:
- ADDR_WIDTH, 32, width of request and memory byte address.
- DATA_WIDTH, 32, request/response data width; must be 32 (4 byte beats).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1=store, 0=load.
- req_a_type  input  1  1=byte access, 0=word access.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data; byte access uses bits [7:0].
- rsp_valid  output  1  response available, held until accepted.
- rsp_ready  input  1  response consumer ready.
- rsp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
- rsp_err  output  1  misaligned word access.
- mem_en  output  1  memory beat strobe.
- mem_we  output  1  memory write.
- mem_addr  output  ADDR_WIDTH  memory byte address.
- mem_wdata  output  8  write byte.
- mem_rdata  input  8  read byte; valid one cycle after a mem_en read beat.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; beat counter and internal registers clear.
  - All outputs 0, except req_ready=1 once in IDLE.
- Reset mid-operation: abandons the transfer immediately and no response is produced. Bytes already written stay written.
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, a_type, addr, wdata.
  - Set N=1 for byte, N=4 for word; clear cnt.
  - Go to ACCESS, except a word access with addr[1:0]!=00 goes directly to RESP with err=1, rdata=0 and no memory beats.
- ACCESS:
  - mem_en=1, mem_addr=addr+cnt (modulo 2^ADDR_WIDTH), mem_we=we.
  - mem_wdata=wdata[8*cnt+:8].
  - Load with cnt>0: capture mem_rdata into rdata[8*(cnt-1)+:8].
  - cnt increments each cycle.
  - At cnt==N-1: store goes to RESP, load goes to DRAIN.
- DRAIN:
  - mem_en=0.
  - Capture mem_rdata into rdata[8*(N-1)+:8], then go to RESP.
  - Byte load fills bits [31:8] per the Optional Feature.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stable.
  - On rsp_ready go to IDLE.
  - New request is accepted no earlier than the cycle after the handshake.
- mem_en=0 outside ACCESS; mem_we never high without mem_en.
- Latency, request accept cycle 0 to rsp_valid:
  - byte store 2 cycles;
  - word store 5 cycles;
  - byte load 3 cycles;
  - word load 6 cycles;
  - misaligned word 1 cycle.
- rsp_rdata is 0 for stores.
- req_valid while not IDLE is ignored (req_ready=0).
- Requester holds request fields stable only during the accept cycle.

Optional Feature:
- Macro LSU_SIGN_EXT_EN.
- Defined: byte loads sign-extend bit 7 into rsp_rdata[31:8] (lb).
- Undefined: byte loads zero-extend (lbu).
- Word loads are unaffected.

Test Plan:
- Word store, addr=0x100, wdata=0xDEADBEEF -> beats cycles 1-4 at 0x100..0x103 with bytes EF,BE,AD,DE; rsp_valid at cycle 5, rsp_err=0.
- Word load from 0x100 after previous store -> rsp_rdata=0xDEADBEEF at cycle 6; exactly 4 mem_en beats with mem_we=0.
- Byte load from 0x103 (byte 0xDE) -> rsp_rdata=0xFFFFFFDE with LSU_SIGN_EXT_EN, 0x000000DE without; rsp_valid at cycle 3.
- Word load, addr=0x102 -> no mem_en; rsp_valid at cycle 1 with rsp_err=1, rsp_rdata=0.
- Byte store to addr 0xFFFFFFFF, wdata=0x12345678 -> single beat, mem_addr=0xFFFFFFFF, mem_wdata=0x78. Hold rsp_ready=0 for 3 cycles -> rsp_valid stays high and req_ready stays 0; then handshake -> IDLE.
- rst_n low during beat 2 of a word store -> all outputs 0 immediately; after release req_ready=1 and no rsp_valid.
